// File: rtl/pc_fetch_gen.sv
// Fetch-PC generator: owns the fetch PC and runs a single-outstanding req/addr/data fetch.
// Define PC_FETCH_GEN_ADEL_CHECK_EN to block misaligned fetches and raise fetch_adel.
module pc_fetch_gen #(
    parameter int          FETCH_W    = 2,
    parameter logic [31:0] RESET_PC   = 32'hbfc00000,
    parameter int          FIFO_CNT_W = 4,
    localparam int         CNT_W      = $clog2(FETCH_W + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pc_en,
    input  logic [FIFO_CNT_W-1:0] fifo_free,
    input  logic                  exc_valid,
    input  logic [31:0]           exc_addr,
    input  logic                  branch_valid,
    input  logic [31:0]           branch_addr,
    output logic                  inst_req,
    output logic [31:0]           inst_addr,
    input  logic                  inst_addr_ok,
    input  logic                  inst_data_ok,
    input  logic [CNT_W-1:0]      inst_rdata_cnt,
    output logic                  fetch_valid,
    output logic [31:0]           fetch_pc,
    output logic [CNT_W-1:0]      fetch_cnt,
    output logic [31:0]           pc_curr
`ifdef PC_FETCH_GEN_ADEL_CHECK_EN
    ,
    output logic                  fetch_adel
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    localparam logic [FIFO_CNT_W:0] FETCH_W_N = (FIFO_CNT_W + 1)'(FETCH_W);

    state_t      state;
    state_t      state_nxt;
    logic        discard;
    logic        discard_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] redir_pc;
    logic        redir;
    logic        fifo_ok;
    logic        misalign;
    logic        launch;

    // Exception beats branch when both fire together.
    assign redir    = exc_valid | branch_valid;
    assign redir_pc = exc_valid ? exc_addr : branch_addr;
    assign fifo_ok  = {1'b0, fifo_free} >= FETCH_W_N;

`ifdef PC_FETCH_GEN_ADEL_CHECK_EN
    assign misalign = |pc_curr[1:0];
`else
    assign misalign = 1'b0;
`endif

    assign launch    = pc_en & fifo_ok & ~misalign;
    assign inst_addr = pc_curr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc_curr <= RESET_PC;
            discard <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_curr <= pc_nxt;
            discard <= discard_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_curr;
        discard_nxt = discard;
        unique case (state)
            IDLE: begin
                if (redir) begin
                    pc_nxt = redir_pc;
                end else if (launch) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // Unaccepted address may be swapped; accepted one goes stale.
                if (redir) begin
                    pc_nxt = redir_pc;
                end
                if (inst_addr_ok) begin
                    state_nxt   = WAIT;
                    discard_nxt = redir;
                end
            end
            WAIT: begin
                if (inst_data_ok) begin
                    state_nxt   = IDLE;
                    discard_nxt = 1'b0;
                    if (redir) begin
                        pc_nxt = redir_pc;
                    end else if (!discard) begin
                        pc_nxt = pc_curr + 32'({inst_rdata_cnt, 2'b00});
                    end
                end else if (redir) begin
                    pc_nxt      = redir_pc;
                    discard_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        inst_req    = (state == REQ);
        fetch_valid = (state == WAIT) & inst_data_ok & ~discard & ~redir;
        fetch_cnt   = fetch_valid ? inst_rdata_cnt : '0;
        fetch_pc    = pc_curr;
`ifdef PC_FETCH_GEN_ADEL_CHECK_EN
        fetch_adel  = (state == IDLE) & misalign;
`endif
    end

endmodule

// File: doc/pc_fetch_gen.md
Name: pc_fetch_gen

Overview:
- Parametrised fetch-PC generator for the multi-issue front end. It replaces the fixed dual-issue PC register.
- Owns the fetch PC and drives an SRAM-like request/address/data handshake to the instruction memory.
- Advances the PC by the number of instructions actually returned, from 1 to FETCH_W.
- Applies exception and branch redirects with fixed priority, and discards in-flight fetches made stale by a redirect.
- Sits between the redirect logic (EX/exception unit) and the instruction FIFO.

Parameters:
FETCH_W, 2, maximum instructions returned per fetch; legal values 1..4
RESET_PC, 32'hbfc00000, PC value loaded on reset
FIFO_CNT_W, 4, width of the fifo_free input

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
pc_en  in  1  fetch enable; when 0, no new request is launched
fifo_free  in  FIFO_CNT_W  free slots in the instruction FIFO
exc_valid  in  1  exception/ERET redirect request
exc_addr  in  32  exception redirect target
branch_valid  in  1  branch/jump redirect request
branch_addr  in  32  branch redirect target
inst_req  out  1  fetch request to instruction memory
inst_addr  out  32  fetch address; equals pc_curr
inst_addr_ok  in  1  memory accepted the address
inst_data_ok  in  1  fetch data returned
inst_rdata_cnt  in  $clog2(FETCH_W+1)  valid instructions returned, 0..FETCH_W
fetch_valid  out  1  returned data is current-path; FIFO may push
fetch_pc  out  32  PC of the first returned instruction
fetch_cnt  out  $clog2(FETCH_W+1)  instructions to push
pc_curr  out  32  current fetch PC

Behaviour:
- Reset (rst_n=0 at clock edge):
  - pc_curr=RESET_PC, state=IDLE, discard=0.
  - inst_req=0, fetch_valid=0, fetch_cnt=0, fetch_pc=RESET_PC.
  - Reset dominates every other input, including mid-request. Any data_ok for a request issued before reset is ignored because state is IDLE.
- States: IDLE, REQ, WAIT. inst_req = (state==REQ). inst_addr = pc_curr.
- Redirect selection: redir = exc_valid | branch_valid. Target is exc_addr if exc_valid, otherwise branch_addr. Exception always wins over branch.
- IDLE:
  - If redir: pc_curr <= target, stay in IDLE.
  - Otherwise, if pc_en && fifo_free >= FETCH_W: go to REQ next cycle.
  - Otherwise: hold.
- REQ:
  - If inst_addr_ok: go to WAIT. discard <= redir. If redir, pc_curr <= target.
  - If no addr_ok and redir: pc_curr <= target, stay in REQ. The new address is presented next cycle; this is legal because the old address was not accepted.
  - pc_en dropping in REQ does not withdraw the request.
- WAIT:
  - redir without data_ok: pc_curr <= target, discard <= 1.
  - data_ok with discard==1 or redir: fetch_valid=0. pc_curr <= target if redir, else unchanged. discard <= 0. Go to IDLE.
  - data_ok with discard==0 and !redir: fetch_valid=1, fetch_pc=pc_curr, fetch_cnt=inst_rdata_cnt. pc_curr <= pc_curr + {inst_rdata_cnt,2'b00}, modulo 2^32 (wraps 0xFFFFFFFC -> 0x00000000). Go to IDLE.
  - inst_rdata_cnt==0 on a valid return: fetch_valid=1, fetch_cnt=0, PC unchanged; the block refetches.
- fetch_valid, fetch_pc and fetch_cnt are combinational from the current cycle. They are valid only in the data_ok cycle; otherwise fetch_valid=0 and fetch_cnt=0.
- At most one outstanding request. The memory must not assert data_ok outside WAIT; any such data_ok is ignored.
- Minimum request interval is 3 cycles (IDLE->REQ->WAIT) when addr_ok and data_ok each arrive in one cycle.

Optional Feature:
- Macro: PC_FETCH_GEN_ADEL_CHECK_EN.
- When defined:
  - Adds output fetch_adel (1 bit, reset 0).
  - In IDLE with pc_curr[1:0]!=0, the block does not go to REQ. fetch_adel=1 and fetch_pc=pc_curr, combinationally, until a redirect arrives.
  - A redirect to an aligned target clears fetch_adel next cycle.
- When undefined:
  - No fetch_adel port.
  - pc_curr[1:0] is ignored: requests issue regardless, and the memory is responsible for alignment.

Test Plan:
- Reset then stream: rst_n low 2 cycles, then pc_en=1, fifo_free=8, addr_ok/data_ok immediate, cnt=2 each -> inst_addr sequence 0xbfc00000, 0xbfc00008, 0xbfc00010; fetch_valid pulses with matching fetch_pc and fetch_cnt=2.
- Partial return: FETCH_W=4, cnt=3 at pc 0xbfc00004 -> fetch_cnt=3, next inst_addr 0xbfc00010.
- Stale data: branch_valid=1, branch_addr=0x80001000 one cycle after addr_ok, data_ok two cycles later with cnt=2 -> fetch_valid=0 on that data_ok; next inst_addr=0x80001000.
- Priority and collision: exc_valid (0xbfc00380) and branch_valid (0x80002000) in the same cycle as data_ok -> fetch_valid=0, pc_curr=0xbfc00380.
- Back-pressure and wrap: fifo_free=1 with FETCH_W=2 -> inst_req stays 0 until fifo_free=2. Then redirect to 0xFFFFFFF8 with cnt=2 -> pc_curr=0x00000000.
- Reset mid-WAIT: rst_n=0 while in WAIT, then a late data_ok -> pc_curr=RESET_PC, fetch_valid=0, state IDLE.
